idli_sqi_mem_m: RTL and testbench
=================================

// Module: idli_sqi_mem_m
//
// PURPOSE
// - SQI SRAM responder: the memory-side end of the SQI link that idli_sqi_m drives.
// - Decodes READ/WRITE instructions, a 16b address and a dummy byte.
// - Streams bytes out of, or into, an internal byte array, one nibble per SCK, MSB nibble first.
// - Used as one of the HI/LO memory pair in core-level benches. Also used as an FPGA on-chip stand-in for the external SRAMs.
//
// PARAMETERS
// - ADDR_W      16  Array address bits (<=16). Depth is 2**ADDR_W bytes. Address bits [15:ADDR_W] are ignored.
// - PAGE_BYTES  32  Page size for page-mode wrap (power of two). Used only with IDLI_SQI_MEM_MODE_EN.
//
// PORTS
// - i_sqi_gck     in   1  Single clock. All logic is posedge. SCK, CS and SIO are oversampled on it.
// - i_sqi_rst     in   1  Reset, synchronous and active-high.
// - i_sqi_sck     in   1  SCK from the controller. Synchronous to gck, at most gck/2.
// - i_sqi_cs      in   1  Chip select, active-low.
// - i_sqi_sio     in   4  slice_t. Controller-driven nibble, sampled on the SCK rise.
// - o_sqi_sio     out  4  slice_t. Read-data nibble.
// - o_sqi_sio_oe  out  1  High while this block drives read data.
//
// BEHAVIOUR
// - Edge detect: sck_q is sck delayed by one gck.
//   - rise = sck & ~sck_q
//   - fall = ~sck & sck_q
// - Reset: all of the following hold until the first non-reset gck.
//   - state = IDLE
//   - o_sqi_sio = 0
//   - o_sqi_sio_oe = 0
//   - mode = SEQ
//   - nibble counter = 0
//   - array contents are not reset
// - States and transitions:
//   - CS high in any state -> IDLE on the next gck. This also applies mid-operation.
//   - On CS high, o_sqi_sio_oe = 0 and any partial write byte is discarded.
//   - IDLE: CS low -> INSTR, counter = 0.
//   - INSTR: 2 nibbles on SCK rises, hi nibble first.
//     - 0x03 -> ADDR (read)
//     - 0x02 -> ADDR (write)
//     - any other value -> ERR
//   - ADDR: 4 nibbles, MSB first, shifted into addr[15:0].
//     - After the 4th rise: read -> DUMMY, write -> WR_DATA.
//   - DUMMY: 2 SCK rises are ignored, then -> RD_DATA.
//   - RD_DATA: on each SCK fall, o_sqi_sio <= next nibble of mem[addr], hi then lo.
//     - Registered: visible one gck after the gck where fall is detected.
//     - o_sqi_sio_oe rises with the first nibble.
//     - addr advances after the lo nibble is loaded.
//   - WR_DATA: nibbles are captured on SCK rises, hi then lo.
//     - mem[addr] is written on the gck of the lo-nibble rise, then addr advances.
//     - A lone hi nibble followed by CS high is dropped and mem is unchanged.
//   - ERR: all SIO is ignored, o_sqi_sio_oe = 0, until CS high.
// - Address advance, SEQ mode: addr + 1 modulo 2**ADDR_W (wraps to 0).
// - Read-after-write of the same address in a later transaction returns the written byte.
// - Simultaneous events:
//   - CS high on the same gck as an SCK rise: CS wins, no capture, no write.
//   - rise and fall cannot coincide (SCK is at most gck/2).
//
// CONFIGURATION
// - IDLI_SQI_MEM_MODE_EN defined: adds an 8b mode register, reset 0x40 (SEQ).
//   - RDMR 0x05: INSTR -> DUMMY (no address phase). Mode byte is then streamed repeatedly in RD_DATA.
//   - WRMR 0x01: INSTR -> WR_DATA (no address phase). The first complete byte is written to mode. Further bytes are ignored.
//   - mode[7:6]: 00 BYTE = addr holds. 10 PAGE = low log2(PAGE_BYTES) bits wrap, upper bits hold. 01 or 11 = SEQ.
// - IDLI_SQI_MEM_MODE_EN undefined:
//   - 0x05 and 0x01 -> ERR
//   - no mode register
//   - always SEQ
//
// TESTING
// - WRITE 0x02, addr 0x1234, data 0xA5 0x3C, CS high; then READ 0x03 at 0x1234 -> read data nibbles A,5,3,C, oe high only in RD_DATA.
// - READ at 0xFFFF (ADDR_W=16), 3 bytes -> bytes from 0xFFFF, 0x0000, 0x0001 (wrap).
// - WRITE 0x77 to 0x0010, then WRITE at 0x0010 with only nibble 0xF and CS high; READ 0x0010 -> 0x77.
// - CS high on the same gck as the 3rd ADDR rise, then a fresh READ at 0x0000 -> decodes cleanly from INSTR, correct data.
// - Instruction 0x9F -> ERR, oe stays 0; then CS low/high and a READ -> normal data.
// - MODE_EN: WRMR 0x80 (PAGE), READ at 0x001F, 2 bytes -> bytes from 0x001F, 0x0000. Without MODE_EN, WRMR -> ERR, later reads stay SEQ.

Source files
------------

// File: rtl/idli_sqi_mem_m.sv
// SQI SRAM responder: decodes READ/WRITE + 16b address + dummy byte and streams nibbles to/from a byte array.
// Optional `IDLI_SQI_MEM_MODE_EN adds the RDMR/WRMR mode register with BYTE/PAGE/SEQ address advance.
module idli_sqi_mem_m #(
    parameter int ADDR_W     = 16,
    parameter int PAGE_BYTES = 32
) (
    input  logic       i_sqi_gck,
    input  logic       i_sqi_rst,
    input  logic       i_sqi_sck,
    input  logic       i_sqi_cs,
    input  logic [3:0] i_sqi_sio,
    output logic [3:0] o_sqi_sio,
    output logic       o_sqi_sio_oe
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INSTR,
        S_ADDR,
        S_DUMMY,
        S_RD_DATA,
        S_WR_DATA,
        S_ERR
    } state_t;

    localparam logic [15:0] PAGE_MASK = 16'(PAGE_BYTES - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sck_q;
    logic        rise, fall;
    logic [3:0]  instr_hi_q;
    logic [3:0]  wr_hi_q;
    logic        is_wr_q;
    logic [15:0] addr_q;
    logic [15:0] addr_inc;
    logic [15:0] addr_adv;
    logic [7:0]  instr;
    logic [7:0]  rd_byte;
    logic [7:0]  wr_byte;
    logic        dec_en, addr_shift, rd_load, wr_hi_en, wr_commit;
    logic        dec_wr, dec_mode;
    logic [7:0]  mem [0:(1 << ADDR_W) - 1];

`ifdef IDLI_SQI_MEM_MODE_EN
    logic [7:0]  mode_q;
    logic        tgt_mode_q;
    logic        mode_done_q;
`endif

    assign rise     = i_sqi_sck & ~sck_q;
    assign fall     = ~i_sqi_sck & sck_q;
    assign instr    = {instr_hi_q, i_sqi_sio};
    assign wr_byte  = {wr_hi_q, i_sqi_sio};
    assign addr_inc = addr_q + 16'd1;

    // Array index uses only the low ADDR_W bits, so plain +1 already wraps the depth.
`ifdef IDLI_SQI_MEM_MODE_EN
    always_comb begin
        addr_adv = addr_inc;
        rd_byte  = tgt_mode_q ? mode_q : mem[addr_q[ADDR_W-1:0]];
        case (mode_q[7:6])
            2'b00:   addr_adv = addr_q;
            2'b10:   addr_adv = (addr_q & ~PAGE_MASK) | (addr_inc & PAGE_MASK);
            default: addr_adv = addr_inc;
        endcase
    end
`else
    assign addr_adv = addr_inc;
    assign rd_byte  = mem[addr_q[ADDR_W-1:0]];
`endif

    always_comb begin
        dec_wr   = 1'b0;
        dec_mode = 1'b0;
        case (instr)
            8'h02:   dec_wr = 1'b1;
`ifdef IDLI_SQI_MEM_MODE_EN
            8'h01: begin
                dec_wr   = 1'b1;
                dec_mode = 1'b1;
            end
            8'h05:   dec_mode = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // CS high overrides every state so an aborted transfer never captures or writes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dec_en     = 1'b0;
        addr_shift = 1'b0;
        rd_load    = 1'b0;
        wr_hi_en   = 1'b0;
        wr_commit  = 1'b0;
        if (i_sqi_cs) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_INSTR;
                    cnt_d   = 3'd0;
                end
                S_INSTR: if (rise) begin
                    if (cnt_q == 3'd0) begin
                        cnt_d = 3'd1;
                    end else begin
                        cnt_d  = 3'd0;
                        dec_en = 1'b1;
                        case (instr)
                            8'h02, 8'h03: state_d = S_ADDR;
`ifdef IDLI_SQI_MEM_MODE_EN
                            8'h05:        state_d = S_DUMMY;
                            8'h01:        state_d = S_WR_DATA;
`endif
                            default:      state_d = S_ERR;
                        endcase
                    end
                end
                S_ADDR: if (rise) begin
                    addr_shift = 1'b1;
                    if (cnt_q == 3'd3) begin
                        cnt_d   = 3'd0;
                        state_d = is_wr_q ? S_WR_DATA : S_DUMMY;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                S_DUMMY: if (rise) begin
                    if (cnt_q == 3'd1) begin
                        cnt_d   = 3'd0;
                        state_d = S_RD_DATA;
                    end else begin
                        cnt_d = 3'd1;
                    end
                end
                S_RD_DATA: if (fall) begin
                    rd_load = 1'b1;
                    cnt_d   = {2'b00, ~cnt_q[0]};
                end
                S_WR_DATA: if (rise) begin
                    if (cnt_q == 3'd0) begin
                        wr_hi_en = 1'b1;
                        cnt_d    = 3'd1;
                    end else begin
                        wr_commit = 1'b1;
                        cnt_d     = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            sck_q        <= 1'b0;
            instr_hi_q   <= 4'd0;
            wr_hi_q      <= 4'd0;
            is_wr_q      <= 1'b0;
            addr_q       <= 16'd0;
            o_sqi_sio    <= 4'd0;
            o_sqi_sio_oe <= 1'b0;
`ifdef IDLI_SQI_MEM_MODE_EN
            mode_q       <= 8'h40;
            tgt_mode_q   <= 1'b0;
            mode_done_q  <= 1'b0;
`endif
        end else begin
            sck_q <= i_sqi_sck;
            if (state_q == S_INSTR && rise && cnt_q == 3'd0) begin
                instr_hi_q <= i_sqi_sio;
            end
            if (dec_en) begin
                is_wr_q <= dec_wr;
`ifdef IDLI_SQI_MEM_MODE_EN
                tgt_mode_q  <= dec_mode;
                mode_done_q <= 1'b0;
`endif
            end
            if (addr_shift) begin
                addr_q <= {addr_q[11:0], i_sqi_sio};
            end
            if (wr_hi_en) begin
                wr_hi_q <= i_sqi_sio;
            end
            // Read nibbles are registered so they appear one gck after the detected fall.
            if (state_d != S_RD_DATA) begin
                o_sqi_sio    <= 4'd0;
                o_sqi_sio_oe <= 1'b0;
            end else if (rd_load) begin
                o_sqi_sio_oe <= 1'b1;
                if (cnt_q[0] == 1'b0) begin
                    o_sqi_sio <= rd_byte[7:4];
                end else begin
                    o_sqi_sio <= rd_byte[3:0];
                    addr_q    <= addr_adv;
                end
            end
`ifdef IDLI_SQI_MEM_MODE_EN
            if (wr_commit) begin
                if (tgt_mode_q) begin
                    if (!mode_done_q) begin
                        mode_q      <= wr_byte;
                        mode_done_q <= 1'b1;
                    end
                end else begin
                    addr_q <= addr_adv;
                end
            end
`else
            if (wr_commit) begin
                addr_q <= addr_adv;
            end
`endif
        end
    end

    always_ff @(posedge i_sqi_gck) begin
`ifdef IDLI_SQI_MEM_MODE_EN
        if (!i_sqi_rst && wr_commit && !tgt_mode_q) begin
`else
        if (!i_sqi_rst && wr_commit) begin
`endif
            mem[addr_q[ADDR_W-1:0]] <= wr_byte;
        end
    end

    logic unused_ok;
    assign unused_ok = dec_mode;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: writes, reads, address wrap, aborted transfers and error instructions.
module tb_idli_sqi_mem_m;

    logic       gck;
    logic       rst;
    logic       sck;
    logic       cs;
    logic [3:0] sio;
    logic [3:0] o_sio;
    logic       o_oe;

    int         check_cnt;
    int         err_cnt;
    logic [7:0] rd_buf [8];
    logic [7:0] wr_buf [8];

    idli_sqi_mem_m #(.ADDR_W(16), .PAGE_BYTES(32)) dut (
        .i_sqi_gck   (gck),
        .i_sqi_rst   (rst),
        .i_sqi_sck   (sck),
        .i_sqi_cs    (cs),
        .i_sqi_sio   (sio),
        .o_sqi_sio   (o_sio),
        .o_sqi_sio_oe(o_oe)
    );

    initial gck = 1'b0;
    always #5 gck = ~gck;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One full SCK period; the sample is taken one gck after the falling edge is seen.
    task automatic applyStimulus(input logic [3:0] nib, output logic [3:0] rd_nib, output logic rd_oe);
        sio = nib;
        sck = 1'b1;
        repeat (2) @(negedge gck);
        sck = 1'b0;
        @(negedge gck);
        rd_nib = o_sio;
        rd_oe  = o_oe;
        @(negedge gck);
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic [3:0] n;
        logic       e;
        applyStimulus(b[7:4], n, e);
        applyStimulus(b[3:0], n, e);
    endtask

    task automatic csLow();
        cs = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    task automatic csHigh();
        cs = 1'b1;
        repeat (2) @(negedge gck);
    endtask

    task automatic doWrite(input logic [15:0] a, input int n);
        csLow();
        sendByte(8'h02);
        sendByte(a[15:8]);
        sendByte(a[7:0]);
        for (int i = 0; i < n; i++) sendByte(wr_buf[i]);
        csHigh();
    endtask

    task automatic doRead(input logic [15:0] a, input int n);
        logic [3:0] nib;
        logic       oe;
        csLow();
        sendByte(8'h03);
        checkOutput("oe_instr", {15'd0, o_oe}, 16'd0);
        sendByte(a[15:8]);
        sendByte(a[7:0]);
        checkOutput("oe_addr", {15'd0, o_oe}, 16'd0);
        applyStimulus(4'h0, nib, oe);
        checkOutput("oe_dummy", {15'd0, oe}, 16'd0);
        for (int i = 0; i < 2 * n; i++) begin
            applyStimulus(4'h0, nib, oe);
            if (i == 0) checkOutput("oe_rd", {15'd0, oe}, 16'd1);
            if (i % 2 == 0) rd_buf[i/2][7:4] = nib;
            else            rd_buf[i/2][3:0] = nib;
        end
        cs = 1'b1;
        @(negedge gck);
        checkOutput("oe_cs", {15'd0, o_oe}, 16'd0);
        @(negedge gck);
    endtask

    initial begin
        logic [3:0] nib;
        logic       oe;
        check_cnt = 0;
        err_cnt   = 0;
        rst = 1'b1;
        sck = 1'b0;
        cs  = 1'b1;
        sio = 4'h0;
        repeat (4) @(negedge gck);
        checkOutput("rst_oe", {15'd0, o_oe}, 16'd0);
        checkOutput("rst_sio", {12'd0, o_sio}, 16'd0);
        rst = 1'b0;
        repeat (2) @(negedge gck);

        // Basic write then read back, nibble by nibble.
        wr_buf[0] = 8'hA5;
        wr_buf[1] = 8'h3C;
        doWrite(16'h1234, 2);
        doRead(16'h1234, 2);
        checkOutput("rd_1234_b0", {8'd0, rd_buf[0]}, 16'h00A5);
        checkOutput("rd_1234_b1", {8'd0, rd_buf[1]}, 16'h003C);

        // Address wrap at the top of the array.
        wr_buf[0] = 8'h11;
        wr_buf[1] = 8'h22;
        wr_buf[2] = 8'h33;
        doWrite(16'hFFFF, 3);
        doRead(16'hFFFF, 3);
        checkOutput("wrap_b0", {8'd0, rd_buf[0]}, 16'h0011);
        checkOutput("wrap_b1", {8'd0, rd_buf[1]}, 16'h0022);
        checkOutput("wrap_b2", {8'd0, rd_buf[2]}, 16'h0033);

        // Lone high nibble followed by CS high leaves memory untouched.
        wr_buf[0] = 8'h77;
        doWrite(16'h0010, 1);
        csLow();
        sendByte(8'h02);
        sendByte(8'h00);
        sendByte(8'h10);
        applyStimulus(4'hF, nib, oe);
        csHigh();
        doRead(16'h0010, 1);
        checkOutput("partial_wr", {8'd0, rd_buf[0]}, 16'h0077);

        // CS rises on the same gck as the 3rd address rise.
        csLow();
        sendByte(8'h03);
        applyStimulus(4'h0, nib, oe);
        applyStimulus(4'h0, nib, oe);
        sio = 4'h0;
        sck = 1'b1;
        cs  = 1'b1;
        repeat (2) @(negedge gck);
        sck = 1'b0;
        repeat (2) @(negedge gck);
        doRead(16'h0000, 1);
        checkOutput("abort_rd", {8'd0, rd_buf[0]}, 16'h0022);

        // Unknown instruction: no output enable for the whole transfer.
        csLow();
        sendByte(8'h9F);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'h3, nib, oe);
            checkOutput("err_oe", {15'd0, oe}, 16'd0);
        end
        csHigh();
        doRead(16'h1234, 1);
        checkOutput("after_err", {8'd0, rd_buf[0]}, 16'h00A5);

        // Mode register: PAGE mode wraps inside the 32-byte page, otherwise WRMR is an error.
        wr_buf[0] = 8'h5A;
        wr_buf[1] = 8'h6B;
        doWrite(16'h001F, 2);
        csLow();
        sendByte(8'h01);
        sendByte(8'h80);
        csHigh();
        doRead(16'h001F, 2);
        checkOutput("mode_b0", {8'd0, rd_buf[0]}, 16'h005A);
`ifdef IDLI_SQI_MEM_MODE_EN
        checkOutput("page_b1", {8'd0, rd_buf[1]}, 16'h0022);
        csLow();
        sendByte(8'h05);
        applyStimulus(4'h0, nib, oe);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'h0, nib, oe);
            checkOutput("rdmr_nib", {12'd0, nib}, (i % 2 == 0) ? 16'h0008 : 16'h0000);
        end
        csHigh();
`else
        checkOutput("seq_b1", {8'd0, rd_buf[1]}, 16'h006B);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
